sync_fifo_v2: RTL and testbench

//  Single-clock FIFO that succeeds sync_fifo.
//  - Any DEPTH >= 2, not only powers of two.
//  - Standard or first-word-fall-through (FWFT) read mode, chosen at elaboration.
//  - Occupancy output, programmable almost-full/almost-empty flags, registered error pulses.
//  - Sits between streaming producers and consumers in the same clock domain.

---
 rtl/sync_fifo_v2.sv | 192 +++++++++++++++++++
 tb/tb_sync_fifo_v2.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2 -- single-clock FIFO with arbitrary depth and an optional
// first-word-fall-through read side.
//
// Parameters
//   WIDTH      data word width in bits (1..256)
//   DEPTH      capacity in words (2..32768, any integer)
//   FWFT       0 = standard read (word appears 1 cycle after i_rd_en),
//              1 = first-word-fall-through (head word always presented)
//   AF_THRESH  o_almost_full  asserts when o_count >= AF_THRESH
//   AE_THRESH  o_almost_empty asserts when o_count <= AE_THRESH
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_data, i_wr_en     write side
//   o_full              o_count == DEPTH
//   o_almost_full       o_count >= AF_THRESH
//   o_wr_err            1-cycle pulse: write requested while full
//   i_rd_en             read request (standard) / pop (FWFT)
//   o_data, o_valid     read data and its qualifier
//   o_empty             standard: o_count == 0; FWFT: !o_valid
//   o_almost_empty      o_count <= AE_THRESH
//   o_rd_err            1-cycle pulse: read requested with nothing to read
//   o_count             words held, including the FWFT output register
//   o_parity_err        parity mismatch on the presented word
//
// Optional feature macro: SYNC_FIFO_V2_PARITY_EN
//   defined   -> RAM stores an even-parity bit per word and o_parity_err
//                reports a mismatch on the presented word while o_valid = 1
//   undefined -> RAM is WIDTH bits wide and o_parity_err is tied to 0
//
// Handshake: a write is accepted when i_wr_en && !o_full; a read is accepted
// when i_rd_en && (standard: o_count != 0, FWFT: o_valid). Both decisions use
// the state before the clock edge, so a same-cycle read never frees room for
// a rejected write and a same-cycle write never satisfies a rejected read.

module sync_fifo_v2 #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_wr_en,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_wr_err,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic                       o_empty,
  output logic                       o_almost_empty,
  output logic                       o_rd_err,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_parity_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef SYNC_FIFO_V2_PARITY_EN
  localparam int RAM_W  = WIDTH + 1;
`else
  localparam int RAM_W  = WIDTH;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_CNT    = CNT_W'(AE_THRESH);

  logic [RAM_W-1:0]  ram [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [RAM_W-1:0]  wr_word;
  logic [RAM_W-1:0]  rd_word;

  logic wr_ok;        // write accepted this cycle
  logic rd_ok;        // read / pop accepted this cycle
  logic rd_reject;    // read requested but nothing to read
  logic ram_wr;       // accepted write lands in RAM (not bypassed)
  logic load_ram;     // output register takes the RAM head word
  logic load_bypass;  // output register takes i_data directly (FWFT, empty)

  // Pointers wrap explicitly at DEPTH-1 so any depth works.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
  endfunction

  assign o_full         = (o_count == FULL_CNT);
  assign o_almost_full  = (o_count >= AF_CNT);
  assign o_almost_empty = (o_count <= AE_CNT);
  assign o_empty        = (FWFT != 0) ? !o_valid : (o_count == '0);

`ifdef SYNC_FIFO_V2_PARITY_EN
  assign wr_word = {^i_data, i_data};
`else
  assign wr_word = i_data;
`endif
  assign rd_word = ram[rd_ptr];

  always_comb begin
    wr_ok       = i_wr_en && !o_full;
    ram_wr      = wr_ok;
    rd_ok       = 1'b0;
    rd_reject   = 1'b0;
    load_ram    = 1'b0;
    load_bypass = 1'b0;
    if (FWFT != 0) begin
      rd_ok     = i_rd_en && o_valid;
      rd_reject = i_rd_en && !o_valid;
      // Output register needs a new word when it is empty or being popped.
      // RAM holds o_count - o_valid words; prefer RAM to keep ordering, and
      // only bypass straight from i_data when RAM is empty.
      if (!o_valid || rd_ok) begin
        if (o_count != {{(CNT_W-1){1'b0}}, o_valid}) begin
          load_ram = 1'b1;
        end else if (wr_ok) begin
          load_bypass = 1'b1;
          ram_wr      = 1'b0;
        end
      end
    end else begin
      rd_ok     = i_rd_en && (o_count != '0);
      rd_reject = i_rd_en && (o_count == '0);
      load_ram  = rd_ok;
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      ram[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_count  <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_wr_err <= 1'b0;
      o_rd_err <= 1'b0;
    end else begin
      if (ram_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (load_ram) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (wr_ok && !rd_ok) begin
        o_count <= o_count + CNT_W'(1);
      end else if (!wr_ok && rd_ok) begin
        o_count <= o_count - CNT_W'(1);
      end
      if (load_ram) begin
        o_data <= rd_word[WIDTH-1:0];
      end else if (load_bypass) begin
        o_data <= i_data;
      end
      // Standard mode: o_valid is a one-cycle strobe per accepted read.
      // FWFT: o_valid only changes when the register is refilled or drained.
      if (FWFT == 0 || !o_valid || rd_ok) begin
        o_valid <= load_ram || load_bypass;
      end
      o_wr_err <= i_wr_en && o_full;
      o_rd_err <= rd_reject;
    end
  end

`ifdef SYNC_FIFO_V2_PARITY_EN
  logic par_q;  // stored parity travelling alongside o_data

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_q <= 1'b0;
    end else if (load_ram) begin
      par_q <= rd_word[WIDTH];
    end else if (load_bypass) begin
      par_q <= ^i_data;
    end
  end

  assign o_parity_err = o_valid && (par_q ^ (^o_data));
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2: three instances share one stimulus stream
// (standard DEPTH=16, standard DEPTH=12, FWFT DEPTH=8). Each is compared every
// cycle against a list-based model of FIFO contents, plus literal checks on
// the directed scenarios.

module tb_sync_fifo_v2;

  localparam int W = 16;
  localparam int N = 3;
  localparam int DEP [N] = '{16, 12, 8};
  localparam bit FW  [N] = '{1'b0, 1'b0, 1'b1};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] dout [N];
  logic [N-1:0] full_v, af_v, wr_err_v, valid_v, empty_v, ae_v, rd_err_v, perr_v;
  logic [4:0]   cnt0;
  logic [3:0]   cnt1;
  logic [3:0]   cnt2;

  sync_fifo_v2 #(.WIDTH(W), .DEPTH(16), .FWFT(0)) u_std16 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_wr_en(wr_en),
    .o_full(full_v[0]), .o_almost_full(af_v[0]), .o_wr_err(wr_err_v[0]),
    .i_rd_en(rd_en), .o_data(dout[0]), .o_valid(valid_v[0]), .o_empty(empty_v[0]),
    .o_almost_empty(ae_v[0]), .o_rd_err(rd_err_v[0]), .o_count(cnt0),
    .o_parity_err(perr_v[0])
  );

  sync_fifo_v2 #(.WIDTH(W), .DEPTH(12), .FWFT(0)) u_std12 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_wr_en(wr_en),
    .o_full(full_v[1]), .o_almost_full(af_v[1]), .o_wr_err(wr_err_v[1]),
    .i_rd_en(rd_en), .o_data(dout[1]), .o_valid(valid_v[1]), .o_empty(empty_v[1]),
    .o_almost_empty(ae_v[1]), .o_rd_err(rd_err_v[1]), .o_count(cnt1),
    .o_parity_err(perr_v[1])
  );

  sync_fifo_v2 #(.WIDTH(W), .DEPTH(8), .FWFT(1)) u_fwft8 (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_wr_en(wr_en),
    .o_full(full_v[2]), .o_almost_full(af_v[2]), .o_wr_err(wr_err_v[2]),
    .i_rd_en(rd_en), .o_data(dout[2]), .o_valid(valid_v[2]), .o_empty(empty_v[2]),
    .o_almost_empty(ae_v[2]), .o_rd_err(rd_err_v[2]), .o_count(cnt2),
    .o_parity_err(perr_v[2])
  );

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // scoreboard bookkeeping
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got=%0h want=%0h", name, inst, $time, act, exp);
    end
  endtask

  // behavioural model: ordered list of held words per instance
  logic [W-1:0] mq [N][16];
  int           msize [N];
  logic [W-1:0] sdata [N];
  bit           sval  [N];
  bit           mwerr [N];
  bit           mrerr [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      msize[i] = 0; sdata[i] = '0; sval[i] = 1'b0; mwerr[i] = 1'b0; mrerr[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        msize[i] = 0; sdata[i] = '0; sval[i] = 1'b0; mwerr[i] = 1'b0; mrerr[i] = 1'b0;
      end else begin
        bit wok, rok;
        wok = wr_en && (msize[i] < DEP[i]);
        rok = rd_en && (msize[i] > 0);
        mwerr[i] = wr_en && (msize[i] == DEP[i]);
        mrerr[i] = rd_en && (msize[i] == 0);
        if (!FW[i]) begin
          sval[i] = rok;
          if (rok) sdata[i] = mq[i][0];
        end
        if (rok) begin
          for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
          msize[i]--;
        end
        if (wok) begin
          mq[i][msize[i]] = din;
          msize[i]++;
        end
      end
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        bit ev;
        ev = FW[i] ? (msize[i] > 0) : sval[i];
        chk("count", i, get_cnt(i), msize[i]);
        chk("full", i, int'(full_v[i]), int'(msize[i] == DEP[i]));
        chk("almost_full", i, int'(af_v[i]), int'(msize[i] >= DEP[i] - 2));
        chk("almost_empty", i, int'(ae_v[i]), int'(msize[i] <= 1));
        chk("empty", i, int'(empty_v[i]), int'(msize[i] == 0));
        chk("valid", i, int'(valid_v[i]), int'(ev));
        chk("wr_err", i, int'(wr_err_v[i]), int'(mwerr[i]));
        chk("rd_err", i, int'(rd_err_v[i]), int'(mrerr[i]));
        chk("parity_err", i, int'(perr_v[i]), 0);
        if (FW[i]) begin
          if (ev) chk("data", i, int'(dout[i]), int'(mq[i][0]));
        end else begin
          chk("data", i, int'(dout[i]), int'(sdata[i]));
        end
      end
    end
  end

  // driver: apply inputs, let one edge pass, return at the following negedge
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pw, pr;

    // reset
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk_en = 1'b1;
    chk("lit_reset_count", 0, int'(cnt0), 0);
    chk("lit_reset_empty", 0, int'(empty_v[0]), 1);
    chk("lit_reset_ae", 0, int'(ae_v[0]), 1);
    chk("lit_reset_full", 0, int'(full_v[0]), 0);
    chk("lit_reset_valid", 2, int'(valid_v[2]), 0);

    // fill 0x0001..0x0010
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 0, W'(k));
      if (k == 13) chk("lit_af_13", 0, int'(af_v[0]), 0);
      if (k == 14) chk("lit_af_14", 0, int'(af_v[0]), 1);
      if (k == 15) chk("lit_full_15", 0, int'(full_v[0]), 0);
    end
    chk("lit_full", 0, int'(full_v[0]), 1);
    chk("lit_count16", 0, int'(cnt0), 16);
    chk("lit_fwft_head", 2, int'(dout[2]), 16'h0001);

    // overflow attempt
    cyc(0, 1, 0, 16'hBEEF);
    chk("lit_wr_err", 0, int'(wr_err_v[0]), 1);
    chk("lit_count_hold", 0, int'(cnt0), 16);
    cyc(0, 0, 0, '0);
    chk("lit_wr_err_pulse", 0, int'(wr_err_v[0]), 0);

    // drain, one extra read to underflow
    for (int k = 1; k <= 17; k++) begin
      cyc(0, 0, 1, '0);
      if (k <= 16) chk("lit_drain", 0, int'(dout[0]), k);
    end
    chk("lit_rd_err", 0, int'(rd_err_v[0]), 1);

    // FWFT write into empty, then pop+write at count 1
    cyc(1, 0, 0, '0);
    cyc(0, 1, 0, 16'hA5A5);
    chk("lit_fwft_valid", 2, int'(valid_v[2]), 1);
    chk("lit_fwft_data", 2, int'(dout[2]), 16'hA5A5);
    cyc(0, 1, 1, 16'h1234);
    chk("lit_fwft_swap", 2, int'(dout[2]), 16'h1234);
    chk("lit_fwft_cnt", 2, int'(cnt2), 1);
    chk("lit_fwft_valid2", 2, int'(valid_v[2]), 1);

    // read while empty with simultaneous write
    cyc(1, 0, 0, '0);
    cyc(0, 1, 1, 16'h5A5A);
    chk("lit_rd_err_wr", 0, int'(rd_err_v[0]), 1);
    chk("lit_cnt_after", 0, int'(cnt0), 1);
    cyc(0, 0, 1, '0);
    chk("lit_word_intact", 0, int'(dout[0]), 16'h5A5A);

    // reset with 7 words held
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, W'($urandom_range(0, 65535)));
    chk("lit_cnt7", 0, int'(cnt0), 7);
    cyc(1, 0, 0, '0);
    chk("lit_rst_cnt", 0, int'(cnt0), 0);
    chk("lit_rst_empty", 0, int'(empty_v[0]), 1);
    chk("lit_rst_valid", 2, int'(valid_v[2]), 0);

    // random traffic with shifting write/read bias and occasional reset
    pw = 50; pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      cyc($urandom_range(0, 399) == 0,
          $urandom_range(0, 99) < pw,
          $urandom_range(0, 99) < pr,
          W'($urandom_range(0, 65535)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
